// File: rtl/nco_sweep_pkg.sv
// Shared types and default constants for the two-tone NCO sweep sequencer.
package nco_sweep_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_DWELL,
      S_STEP,
      S_DONE
   } state_t;

   localparam int NUM_TONES        = 2;
   localparam int DEF_PHASE_W      = 32;
   localparam int DEF_DWELL_W      = 24;
   localparam int DEF_STEPS_W      = 16;
   localparam int DEF_NCO_RST_CYC  = 4;
   localparam int DEF_SETTLE_CYC   = 8;
   localparam int DEF_VALID_TO     = 1024;

   // Bits needed to hold a count of v-1 down to zero.
   function automatic int cnt_w(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control/register-side bundle of the sweep sequencer: request, config and status.
interface nco_sweep_ctrl_if
   import nco_sweep_pkg::*;
#(
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int DWELL_W = DEF_DWELL_W,
   parameter int STEPS_W = DEF_STEPS_W
);
   logic               start;
   logic               stop;
   logic [PHASE_W-1:0] f_start1;
   logic [PHASE_W-1:0] f_start2;
   logic [PHASE_W-1:0] f_step1;
   logic [PHASE_W-1:0] f_step2;
   logic [STEPS_W-1:0] num_steps;
   logic [DWELL_W-1:0] dwell;
   logic [STEPS_W-1:0] step_idx;
   logic               busy;
   logic               done;
   logic               error;

   modport master (
      output start, stop, f_start1, f_start2, f_step1, f_step2, num_steps, dwell,
      input  step_idx, busy, done, error
   );

   modport slave (
      input  start, stop, f_start1, f_start2, f_step1, f_step2, num_steps, dwell,
      output step_idx, busy, done, error
   );
endinterface

// File: rtl/nco_sweep_timer.sv
// Loadable down-counter that parks at zero; zero flag is taken straight off the register.
module nco_sweep_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)               cnt <= '0;
      else if (load)         cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/nco_sweep_ctrl.sv
// Two-tone NCO sweep sequencer: programs increments, sequences NCO reset/settle/dwell per tone.
module nco_sweep_ctrl
   import nco_sweep_pkg::*;
#(
   parameter int PHASE_W     = DEF_PHASE_W,
   parameter int DWELL_W     = DEF_DWELL_W,
   parameter int STEPS_W     = DEF_STEPS_W,
   parameter int NCO_RST_CYC = DEF_NCO_RST_CYC,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int VALID_TO    = DEF_VALID_TO
) (
   input  logic               clk,
   input  logic               rst,
   nco_sweep_ctrl_if.slave    ctl,
   input  logic               nco_valid_i,
   output logic [PHASE_W-1:0] phi_inc1_o,
   output logic [PHASE_W-1:0] phi_inc2_o,
   output logic               nco_reset_n_o,
   output logic               nco_clken_o,
   output logic               sample_valid
);
   localparam int TW = max2(DWELL_W, max2(cnt_w(VALID_TO), max2(cnt_w(NCO_RST_CYC), cnt_w(SETTLE_CYC))));
   localparam logic [TW-1:0] RST_V = TW'(NCO_RST_CYC - 1);
   localparam logic [TW-1:0] SET_V = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] TO_V  = TW'(VALID_TO - 1);

   typedef struct packed {
      logic [NUM_TONES-1:0][PHASE_W-1:0] f_step;
      logic [STEPS_W-1:0]                num_steps;
      logic [DWELL_W-1:0]                dwell;
   } cfg_t;

   state_t state, nx;
   cfg_t   cfg;
   logic   flushing, flush_nx;
   logic   tmr_ld, tmr_zero;
   logic [TW-1:0] tmr_val, dwell_v;
   logic   err_nx, latch, load_phi, do_step;
   logic   nco_en, busy_q, done_q, err_q;
   logic [STEPS_W-1:0] step_idx_q;
   logic [STEPS_W:0]   idx_next;
   logic [NUM_TONES-1:0][PHASE_W-1:0] phi, f_start_in, f_step_in;

   assign f_start_in = {ctl.f_start2, ctl.f_start1};
   assign f_step_in  = {ctl.f_step2, ctl.f_step1};
   assign dwell_v    = (cfg.dwell == '0) ? '0 : TW'(cfg.dwell - DWELL_W'(1));
   assign idx_next   = {1'b0, step_idx_q} + (STEPS_W+1)'(1);

   nco_sweep_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_ld),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      nx       = state;
      flush_nx = flushing;
      tmr_ld   = 1'b0;
      tmr_val  = '0;
      err_nx   = 1'b0;
      latch    = 1'b0;
      load_phi = 1'b0;
      do_step  = 1'b0;
      case (state)
         S_IDLE: if (ctl.start && !ctl.stop) begin
            latch = 1'b1;
            if (ctl.num_steps == '0) begin
               nx = S_DONE;
            end else begin
               nx       = S_LOAD;
               load_phi = 1'b1;
               tmr_ld   = 1'b1;
               tmr_val  = RST_V;
            end
         end
         S_LOAD: if (tmr_zero) begin
            nx       = S_SETTLE;
            flush_nx = 1'b0;
            tmr_ld   = 1'b1;
            tmr_val  = TO_V;
         end
         // Two phases share one timer: valid-wait with timeout, then pipeline flush.
         S_SETTLE: if (!flushing) begin
            if (nco_valid_i) begin
               flush_nx = 1'b1;
               tmr_ld   = 1'b1;
               tmr_val  = SET_V;
            end else if (tmr_zero) begin
               nx     = S_IDLE;
               err_nx = 1'b1;
            end
         end else if (tmr_zero) begin
            nx      = S_DWELL;
            tmr_ld  = 1'b1;
            tmr_val = dwell_v;
         end
         S_DWELL: if (!nco_valid_i) begin
            nx       = S_SETTLE;
            flush_nx = 1'b0;
            tmr_ld   = 1'b1;
            tmr_val  = TO_V;
         end else if (tmr_zero) begin
            nx = (idx_next < {1'b0, cfg.num_steps}) ? S_STEP : S_DONE;
         end
         // NCOs stay running across a step, so valid is already up: go straight to flush.
         S_STEP: begin
            nx       = S_SETTLE;
            flush_nx = 1'b1;
            tmr_ld   = 1'b1;
            tmr_val  = SET_V;
            do_step  = 1'b1;
         end
         S_DONE:  nx = S_IDLE;
         default: nx = S_IDLE;
      endcase
      if (state != S_IDLE && ctl.stop) begin
         nx      = S_IDLE;
         err_nx  = 1'b0;
         do_step = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         flushing     <= 1'b0;
         cfg          <= '0;
         phi          <= '0;
         step_idx_q   <= '0;
         nco_en       <= 1'b0;
         sample_valid <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state    <= nx;
         flushing <= flush_nx;
         if (latch) begin
            cfg.f_step    <= f_step_in;
            cfg.num_steps <= ctl.num_steps;
            cfg.dwell     <= ctl.dwell;
         end
         if (load_phi) begin
            phi        <= f_start_in;
            step_idx_q <= '0;
         end else if (do_step) begin
            for (int t = 0; t < NUM_TONES; t++) phi[t] <= phi[t] + cfg.f_step[t];
            step_idx_q <= step_idx_q + STEPS_W'(1);
         end
         // Released on first SETTLE entry, held through DONE; a zero-tone sweep never releases.
         if (nx == S_SETTLE)                 nco_en <= 1'b1;
         else if (nx inside {S_IDLE, S_LOAD}) nco_en <= 1'b0;
         sample_valid <= (nx == S_DWELL);
         busy_q       <= (nx != S_IDLE);
         done_q       <= (nx == S_DONE);
         err_q        <= err_nx;
      end
   end

   assign phi_inc1_o    = phi[0];
   assign phi_inc2_o    = phi[1];
   assign nco_reset_n_o = nco_en;
   assign nco_clken_o   = nco_en;
   assign ctl.step_idx  = step_idx_q;
   assign ctl.busy      = busy_q;
   assign ctl.done      = done_q;
   assign ctl.error     = err_q;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: tabled full sweeps plus hand-written abort/timeout/reset cases.
module tb_nco_sweep_ctrl;
   import nco_sweep_pkg::*;

   logic clk, rst, nco_valid_i;
   logic [31:0] phi_inc1_o, phi_inc2_o;
   logic nco_reset_n_o, nco_clken_o, sample_valid;
   int n_tests = 0, n_fail = 0;

   nco_sweep_ctrl_if ctl();

   nco_sweep_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ctl           (ctl),
      .nco_valid_i   (nco_valid_i),
      .phi_inc1_o    (phi_inc1_o),
      .phi_inc2_o    (phi_inc2_o),
      .nco_reset_n_o (nco_reset_n_o),
      .nco_clken_o   (nco_clken_o),
      .sample_valid  (sample_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] f1, f2, s1, s2;
      logic [15:0] n;
      logic [23:0] dwell;
      int          vat;
      int          first_sv, nwin, wlen, gap, done_cyc;
      logic [31:0] last1, last2;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   task automatic drive_cfg(input logic [31:0] f1, f2, s1, s2, input logic [15:0] n, input logic [23:0] dw);
      ctl.f_start1 = f1; ctl.f_start2 = f2;
      ctl.f_step1 = s1;  ctl.f_step2 = s2;
      ctl.num_steps = n; ctl.dwell = dw;
   endtask

   // Config is scrambled right after start to prove the latched copy is used.
   task automatic run_vec(input int id, input vec_t v);
      int cyc, win, wlen, lowcnt, dcnt, dcyc;
      logic prev, rise, fall;
      logic [31:0] m1, m2;
      bit fin;
      m1 = v.f1; m2 = v.f2; win = 0; wlen = 0; lowcnt = 0; dcnt = 0; dcyc = -1; prev = 0; fin = 0;
      @(negedge clk);
      drive_cfg(v.f1, v.f2, v.s1, v.s2, v.n, v.dwell);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      drive_cfg(~v.f1, ~v.f2, 32'h5A5A5A5A, 32'hA5A5A5A5, 16'hFFFF, 24'd7);
      cyc = 1;
      chk($sformatf("v%0d busy_c1", id), ctl.busy, 1);
      chk($sformatf("v%0d phi1_c1", id), phi_inc1_o, v.f1);
      chk($sformatf("v%0d phi2_c1", id), phi_inc2_o, v.f2);
      while (!fin && cyc < 2000) begin
         nco_valid_i = (cyc >= v.vat);
         if (cyc == DEF_NCO_RST_CYC)     chk($sformatf("v%0d rstn_low", id), nco_reset_n_o, 0);
         if (cyc == DEF_NCO_RST_CYC + 1) chk($sformatf("v%0d rstn_rise", id), {nco_reset_n_o, nco_clken_o}, 2'b11);
         rise = sample_valid && !prev;
         fall = !sample_valid && prev;
         if (fall) begin
            chk($sformatf("v%0d win%0d_len", id, win), wlen, v.wlen);
            win++; lowcnt = 0; m1 += v.s1; m2 += v.s2;
         end
         if (rise) begin
            if (win == 0) chk($sformatf("v%0d first_sv", id), cyc, v.first_sv);
            else          chk($sformatf("v%0d gap%0d", id, win), lowcnt, v.gap);
            chk($sformatf("v%0d idx%0d", id, win), ctl.step_idx, win);
            chk($sformatf("v%0d phi1_w%0d", id, win), phi_inc1_o, m1);
            chk($sformatf("v%0d phi2_w%0d", id, win), phi_inc2_o, m2);
            wlen = 0;
         end
         if (sample_valid) wlen++; else lowcnt++;
         if (ctl.done) begin
            dcnt++;
            if (dcyc < 0) dcyc = cyc;
         end
         if (dcyc >= 0 && cyc == dcyc + 1) begin
            chk($sformatf("v%0d busy_after_done", id), ctl.busy, 0);
            chk($sformatf("v%0d done_width", id), ctl.done, 0);
            fin = 1;
         end
         prev = sample_valid;
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) bound_fail($sformatf("v%0d sweep_end", id));
      chk($sformatf("v%0d done_cyc", id), dcyc, v.done_cyc);
      chk($sformatf("v%0d done_cnt", id), dcnt, 1);
      chk($sformatf("v%0d nwin", id), win, v.nwin);
      chk($sformatf("v%0d last_phi1", id), phi_inc1_o, v.last1);
      chk($sformatf("v%0d last_phi2", id), phi_inc2_o, v.last2);
      nco_valid_i = 1'b0;
   endtask

   initial begin
      int cyc, cnt;
      bit seen;
      // f1, f2, s1, s2, n, dwell, vat, first_sv, nwin, wlen, gap, done_cyc, last1, last2
      vecs[0] = '{32'h0CCCCCCD, 32'h40000000, 32'h0, 32'h0, 16'd1, 24'd100, 5, 14, 1, 100, 9, 114,
                  32'h0CCCCCCD, 32'h40000000};
      vecs[1] = '{32'h10000000, 32'h20000000, 32'h01000000, 32'h00100000, 16'd3, 24'd10, 7, 16, 3, 10, 9, 64,
                  32'h12000000, 32'h20200000};
      vecs[2] = '{32'hFFFFFFF0, 32'h00000000, 32'h00000020, 32'hFFFFFFFF, 16'd2, 24'd3, 5, 14, 2, 3, 9, 29,
                  32'h00000010, 32'hFFFFFFFF};
      vecs[3] = '{32'h00000001, 32'h00000005, 32'h00000002, 32'h00000000, 16'd2, 24'd0, 9, 18, 2, 1, 9, 29,
                  32'h00000003, 32'h00000005};

      rst = 1'b1; nco_valid_i = 1'b0; ctl.start = 1'b0; ctl.stop = 1'b0;
      drive_cfg(32'h0, 32'h0, 32'h0, 32'h0, 16'd0, 24'd0);
      repeat (3) @(negedge clk);
      chk("rst phi1", phi_inc1_o, 0);
      chk("rst phi2", phi_inc2_o, 0);
      chk("rst step_idx", ctl.step_idx, 0);
      chk("rst rstn/clken", {nco_reset_n_o, nco_clken_o}, 0);
      chk("rst sv/busy/done/err", {sample_valid, ctl.busy, ctl.done, ctl.error}, 0);
      rst = 1'b0;

      // Zero-tone sweep: straight to DONE, NCOs never leave reset, increments untouched.
      @(negedge clk);
      drive_cfg(32'h00001234, 32'h00005678, 32'h1, 32'h1, 16'd0, 24'd5);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      chk("z done_c1", ctl.done, 1);
      chk("z busy_c1", ctl.busy, 1);
      chk("z phi1_kept", phi_inc1_o, 0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (nco_reset_n_o || nco_clken_o) cnt++;
         @(negedge clk);
         if (i == 0) chk("z done_busy_c2", {ctl.done, ctl.busy}, 0);
      end
      chk("z nco_never_released", cnt, 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Valid never arrives: timeout error, back to IDLE with NCOs in reset.
      @(negedge clk);
      drive_cfg(32'h1, 32'h2, 32'h0, 32'h0, 16'd1, 24'd10);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      cyc = 1; seen = 0;
      while (!seen && cyc < DEF_VALID_TO + 100) begin
         if (ctl.error) seen = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!seen) bound_fail("to error_pulse");
      chk("to error_cyc", cyc, DEF_NCO_RST_CYC + 1 + DEF_VALID_TO);
      chk("to idle_busy", ctl.busy, 0);
      chk("to rstn_low", {nco_reset_n_o, nco_clken_o}, 0);
      chk("to no_done", ctl.done, 0);
      @(negedge clk);
      chk("to error_width", ctl.error, 0);

      // stop mid-DWELL, then start+stop together: block stays idle, no done.
      @(negedge clk);
      drive_cfg(32'h11111111, 32'h22222222, 32'h1, 32'h1, 16'd2, 24'd50);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      for (cyc = 1; cyc < 20; cyc++) begin
         nco_valid_i = (cyc >= 5);
         @(negedge clk);
      end
      chk("st sv_before_stop", {sample_valid, ctl.busy}, 2'b11);
      ctl.stop = 1'b1;
      @(negedge clk);
      chk("st sv_dropped", sample_valid, 0);
      chk("st idle", {ctl.busy, ctl.done, ctl.error, nco_reset_n_o}, 0);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0; ctl.stop = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (ctl.busy || ctl.done) cnt++;
         @(negedge clk);
      end
      chk("st start_stop_ignored", cnt, 0);
      nco_valid_i = 1'b0;

      // A second start while busy must not reload increments or restart the sweep.
      drive_cfg(32'hAAAA0000, 32'h0, 32'h0, 32'h0, 16'd1, 24'd5);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      @(negedge clk);
      drive_cfg(32'h55550000, 32'h1, 32'h0, 32'h0, 16'd0, 24'd5);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      chk("bz phi1_kept", phi_inc1_o, 32'hAAAA0000);
      chk("bz busy", {ctl.busy, ctl.done}, 2'b10);
      repeat (3) @(negedge clk);
      chk("bz nco_released", nco_reset_n_o, 1);
      ctl.stop = 1'b1;
      @(negedge clk);
      ctl.stop = 1'b0;
      chk("bz stopped", {ctl.busy, ctl.done}, 0);

      // rst during the second STEP cycle.
      @(negedge clk);
      drive_cfg(32'h00000100, 32'h00000200, 32'h10, 32'h20, 16'd3, 24'd4);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      for (cyc = 1; cyc < 31; cyc++) begin
         nco_valid_i = (cyc >= 5);
         @(negedge clk);
      end
      chk("rs in_step", {sample_valid, ctl.busy}, 2'b01);
      chk("rs idx_before", ctl.step_idx, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nco_valid_i = 1'b0;
      chk("rs phi", {phi_inc1_o, phi_inc2_o}, 0);
      chk("rs step_idx", ctl.step_idx, 0);
      chk("rs outs", {nco_reset_n_o, nco_clken_o, sample_valid, ctl.busy, ctl.done, ctl.error}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
